// File: rtl/uart_pkg.sv
// Shared UART types and defaults, used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int DEFAULT_CLKS_PER_BIT = 434;
  localparam int DEFAULT_DATA_BITS    = 8;

endpackage

// File: rtl/uart_tx_framer_if.sv
// Byte-stream valid/ready handshake between a byte source and the UART transmitter.
interface uart_tx_framer_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: tick marks the last clk of each bit; clr restarts the period.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturates at LAST rather than wrapping; only clr brings it back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmitter: one byte per handshake, LSB first, 1 or 2 stop bits.
// Define UART_PARITY_EN to insert a parity bit (sense set by PARITY_ODD) after the data bits.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEFAULT_DATA_BITS,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_tx_framer_if.slave  s_if,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 8 ||
      (STOP_BITS != 1 && STOP_BITS != 2) || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
    $error("uart_tx_framer: illegal parameter value");
  end

  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                 tx_q, tx_d;
  logic                 ready_en_q;
  logic                 tick;
  logic                 baud_clr;
  logic                 handshake;
`ifdef UART_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  // ready_en_q keeps s_ready low until the first clk edge after reset release.
  assign s_if.s_ready = ready_en_q && (state_q == IDLE);
  assign handshake    = s_if.s_valid && s_if.s_ready;
  assign baud_clr     = (state_q == IDLE) || tick;

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (baud_clr),
    .tick  (tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    done      = 1'b0;
`ifdef UART_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (handshake) begin
          shift_d   = s_if.s_data[DATA_BITS-1:0];
          bit_cnt_d = '0;
          state_d   = START;
`ifdef UART_PARITY_EN
          parity_d  = (^s_if.s_data[DATA_BITS-1:0]) ^ 1'(PARITY_ODD);
`endif
        end
      end
      START: begin
        if (tick) state_d = DATA;
      end
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
`ifdef UART_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (tick) state_d = STOP;
      end
`endif
      STOP: begin
        if (tick) begin
          if (bit_cnt_q == LAST_STOP) begin
            done      = 1'b1;
            bit_cnt_d = '0;
            state_d   = IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // tx is registered, so it is derived from where the FSM is going next.
    tx_d = 1'b1;
    case (state_d)
      START:  tx_d = 1'b0;
      DATA:   tx_d = shift_d[0];
`ifdef UART_PARITY_EN
      PARITY: tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      tx_q       <= 1'b1;
      ready_en_q <= 1'b0;
`ifdef UART_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_q       <= tx_d;
      ready_en_q <= 1'b1;
`ifdef UART_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign tx   = tx_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_framer.sv
// Randomized self-checking bench: two framers (1 and 2 stop bits) against a bit-list frame model.
module tb_uart_tx_framer;

  localparam int CPB = 4;
`ifdef UART_PARITY_EN
  localparam int PBIT = 1;
`else
  localparam int PBIT = 0;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] sd [2];
  logic       sv [2];
  logic [1:0] tx_w, busy_w, done_w, rdy_w;

  int n_checks = 0;
  int n_pass   = 0;

  uart_tx_framer_if bus0 ();
  uart_tx_framer_if bus1 ();

  assign bus0.s_data  = sd[0];
  assign bus0.s_valid = sv[0];
  assign bus1.s_data  = sd[1];
  assign bus1.s_valid = sv[1];
  assign rdy_w[0]     = bus0.s_ready;
  assign rdy_w[1]     = bus1.s_ready;

  uart_tx_framer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .s_if  (bus0),
    .tx    (tx_w[0]),
    .busy  (busy_w[0]),
    .done  (done_w[0])
  );

  uart_tx_framer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .s_if  (bus1),
    .tx    (tx_w[1]),
    .busy  (busy_w[1]),
    .done  (done_w[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int stop_bits(input int u);
    return (u == 0) ? 1 : 2;
  endfunction

  function automatic int frame_len(input int u);
    return (1 + 8 + PBIT + stop_bits(u)) * CPB;
  endfunction

  // Level of UART bit number i of the frame carrying d (0 = start bit).
  function automatic logic exp_bit(input int u, input logic [7:0] d, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return d[i-1];
`ifdef UART_PARITY_EN
    if (i == 9) return (^d) ^ (u == 1);
`endif
    return 1'b1;
  endfunction

  task automatic wait_ready(input int u);
    int n = 0;
    while (!rdy_w[u] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("hs_ready", 32'(rdy_w[u]), 32'd1);
  endtask

  // Handshake happens at the next posedge; the source then holds valid with nd
  // for the last `pre` busy cycles and toggles s_data with valid low before that.
  task automatic send(input int u, input logic [7:0] d, input int pre, input logic [7:0] nd);
    int         len;
    logic [7:0] dec;
    len   = frame_len(u);
    dec   = 8'h00;
    sd[u] = d;
    sv[u] = 1'b1;
    wait_ready(u);
    @(posedge clk);
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      if (k >= len - pre) begin
        sv[u] = 1'b1;
        sd[u] = nd;
      end else begin
        sv[u] = 1'b0;
        sd[u] = 8'($urandom);
      end
      check_eq("tx_bit", 32'(tx_w[u]), 32'(exp_bit(u, d, k / CPB)));
      check_eq("done", 32'(done_w[u]), 32'(k == len - 1));
      check_eq("ready_busy", 32'(rdy_w[u]), 32'd0);
      check_eq("busy", 32'(busy_w[u]), 32'd1);
      if (k >= CPB && k < 9 * CPB && (k % CPB) == CPB / 2) dec[(k / CPB) - 1] = tx_w[u];
    end
    @(negedge clk);
    check_eq("idle_tx", 32'(tx_w[u]), 32'd1);
    check_eq("idle_ready", 32'(rdy_w[u]), 32'd1);
    check_eq("idle_busy", 32'(busy_w[u]), 32'd0);
    check_eq("idle_done", 32'(done_w[u]), 32'd0);
    check_eq("decoded", 32'(dec), 32'(d));
    $display("frame dut%0d data=%02h len=%0d decoded=%02h", u, d, len, dec);
  endtask

  initial begin
    int         u;
    int         pre;
    int         gap;
    bit         chained;
    logic [7:0] cur;
    logic [7:0] nd;

    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sd[i] = 8'h00;
      sv[i] = 1'b0;
    end
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check_eq("rst_tx", 32'(tx_w[i]), 32'd1);
      check_eq("rst_ready", 32'(rdy_w[i]), 32'd0);
      check_eq("rst_busy", 32'(busy_w[i]), 32'd0);
      check_eq("rst_done", 32'(done_w[i]), 32'd0);
    end
    rst_n = 1'b1;
    #1 check_eq("ready_before_edge", 32'(rdy_w[0]), 32'd0);
    @(negedge clk);
    check_eq("ready_after_edge", 32'(rdy_w[0]), 32'd1);

    // Single byte, then back-to-back 0x00 -> 0xFF with valid held throughout.
    send(0, 8'hA5, 0, 8'h00);
    send(0, 8'h00, frame_len(0), 8'hFF);
    send(0, 8'hFF, 0, 8'h00);

    // Junk on s_data with valid low, then 0x3C presented while the previous frame runs.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sd[0] = 8'($urandom);
    end
    send(0, 8'h11, 5, 8'h3C);
    send(0, 8'h3C, 0, 8'h00);

    // Reset in the middle of a 0x81 frame.
    sd[0] = 8'h81;
    sv[0] = 1'b1;
    wait_ready(0);
    @(posedge clk);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      sv[0] = 1'b0;
      sd[0] = 8'($urandom);
    end
    check_eq("pre_rst_tx", 32'(tx_w[0]), 32'd0);
    check_eq("pre_rst_busy", 32'(busy_w[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_tx", 32'(tx_w[0]), 32'd1);
    check_eq("midrst_busy", 32'(busy_w[0]), 32'd0);
    check_eq("midrst_done", 32'(done_w[0]), 32'd0);
    check_eq("midrst_ready", 32'(rdy_w[0]), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("midrst_hold_done", 32'(done_w[0]), 32'd0);
      check_eq("midrst_hold_tx", 32'(tx_w[0]), 32'd1);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_ready", 32'(rdy_w[0]), 32'd1);
    send(0, 8'h55, 0, 8'h00);

    // Two stop bits, and parity sense on both instances.
    send(1, 8'hFF, 0, 8'h00);
    send(0, 8'h07, 0, 8'h00);
    send(1, 8'h07, 0, 8'h00);

    // Randomized frames, gaps and back-to-back chains.
    chained = 1'b0;
    u       = 0;
    cur     = 8'h00;
    for (int i = 0; i < 16; i++) begin
      if (!chained) begin
        u   = $urandom_range(0, 1);
        cur = 8'($urandom);
        gap = $urandom_range(0, 3);
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          sd[u] = 8'($urandom);
        end
      end
      nd      = 8'($urandom);
      pre     = ($urandom_range(0, 1) == 1) ? $urandom_range(1, frame_len(u)) : 0;
      chained = (pre > 0) && (i < 15);
      if (i == 15) pre = 0;
      send(u, cur, pre, nd);
      cur = nd;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_framer.md
Name: uart_tx_framer

Overview:
- Byte-stream-to-serial UART transmitter. Feeds the TX pin from the loopback FIFO's read side, or from any valid/ready byte source.
- Accepts one byte per frame over a valid/ready handshake. Generates its own bit timing from a clock divisor.
- Emits 8N1 frames by default (LSB first). Parity and stop-bit count are configurable.
- Counterpart to the team's UART receiver. Frames produced here are decodable by it at the same divisor.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200). Legal range ≥ 2.
- DATA_BITS, 8, payload bits per frame. Legal range 5..8.
- STOP_BITS, 1, stop bits per frame. Legal values 1 or 2.
- PARITY_ODD, 0, parity sense: 0 = even, 1 = odd. Has effect only with UART_PARITY_EN.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- s_data  input  8  byte to send; bits above DATA_BITS-1 are ignored
- s_valid  input  1  source has a byte on s_data
- s_ready  output  1  block can accept a byte this cycle
- tx  output  1  serial line, idle high, registered
- busy  output  1  high while a frame is in progress (any state other than IDLE)
- done  output  1  one-cycle pulse on the last clk of the final stop bit

Behaviour:
- Reset (clk and rst_n are already decided):
  - rst_n is asynchronous and active-low; clk is the only clock.
  - During reset: tx=1, s_ready=0, busy=0, done=0, state=IDLE, counters=0.
  - s_ready rises on the first clk edge after reset deassertion.
- States: IDLE, START, DATA, PARITY (macro only), STOP.
- IDLE:
  - tx=1, s_ready=1.
  - A handshake (s_valid && s_ready at a clk edge) latches s_data into the shift register, clears the bit counter and moves to START.
  - tx falls on that same edge. Latency is 1 clk from handshake to start bit.
- Data is sampled only at the handshake. Later changes to s_data are ignored.
- s_ready=0 in every non-IDLE state. While it is low, s_valid stays pending and s_data must be held by the source; the block does not drop it.
- Baud counter:
  - Runs 0..CLKS_PER_BIT-1 and is cleared on every bit boundary.
  - Every bit, including start and stop bits, lasts exactly CLKS_PER_BIT clks.
- START: tx=0 for one bit period, then DATA.
- DATA:
  - tx = shift_reg[0]; the register shifts right at each bit boundary, so bits go LSB first.
  - After DATA_BITS bits the block moves to PARITY if the macro is defined, otherwise to STOP.
- STOP:
  - tx=1 for STOP_BITS bit periods.
  - done=1 during the final clk of the last stop bit; the block then returns to IDLE.
- Frame length is (1 + DATA_BITS + P + STOP_BITS) × CLKS_PER_BIT clks, where P is 1 with parity and 0 without.
- Back-to-back frames: at least one idle clk with tx=1 between the end of a stop bit and the next start bit. No other gap is inserted.
- Reset mid-frame: tx returns to 1 immediately (asynchronously), the frame is abandoned, and no done pulse is issued.
- Widths:
  - Bit counter is $clog2(DATA_BITS+1) bits wide.
  - Baud counter is $clog2(CLKS_PER_BIT) bits wide.
  - Neither counter wraps except by an explicit clear.

Optional Feature:
- Macro: UART_PARITY_EN.
- Defined:
  - PARITY state is inserted after DATA.
  - tx = ^data[DATA_BITS-1:0] ^ PARITY_ODD for one bit period.
  - Parity is computed from the latched byte at the handshake.
- Undefined:
  - No PARITY state, no parity logic.
  - PARITY_ODD is ignored.

Decomposition:
- Package uart_pkg:
  - state enum typedef (IDLE/START/DATA/PARITY/STOP), 3 bits wide.
  - localparam defaults DEFAULT_CLKS_PER_BIT=434 and DEFAULT_DATA_BITS=8.
  - Shared with the receiver.
- Sub-module uart_baud_tick:
  - Parameter CLKS_PER_BIT; inputs clk, rst_n, clr.
  - Output tick, high on count == CLKS_PER_BIT-1.
  - Reusable by the receiver.

Test Plan:
- Single byte:
  - Stimulus: CLKS_PER_BIT=4, send 0xA5.
  - Required: tx bit sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 clks. done pulses at clk 40 after the handshake. s_ready is low for 40 clks, then returns high.
- Back-to-back:
  - Stimulus: s_valid held high with 0x00 then 0xFF.
  - Required: two frames, exactly one idle-high clk between them. Decoded bytes are 0x00, 0xFF. Two done pulses.
- Data held while busy:
  - Stimulus: present 0x3C while a frame is in progress, and toggle s_data on earlier cycles before the handshake.
  - Required: the value sent is the s_data present at the handshake edge only.
- Reset mid-frame:
  - Stimulus: assert rst_n at clk 15 of a 0x81 frame (CLKS_PER_BIT=4).
  - Required: tx=1 within the same cycle, no done, busy=0. A post-reset 0x55 is sent cleanly.
- STOP_BITS=2:
  - Stimulus: send 0xFF with STOP_BITS=2, CLKS_PER_BIT=4.
  - Required: stop level high for 8 clks. done comes 44 clks after the handshake.
- UART_PARITY_EN:
  - Stimulus: send 0x07, once with PARITY_ODD=0 and once with PARITY_ODD=1.
  - Required: parity bit is 1 for PARITY_ODD=0 and 0 for PARITY_ODD=1. Frame is 44 clks at CLKS_PER_BIT=4.
